// File: rtl/inst_queue.sv
// inst_queue: multi-lane fetch-to-issue instruction FIFO.
// Valid write lanes are compacted into consecutive slots in program order.
// The READ_PORT oldest entries are presented to issue, and the consumer pops
// 0..READ_PORT of them per cycle. All outputs come from registered state only.
module inst_queue #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned WRITE_PORT  = 2,
  parameter int unsigned READ_PORT   = 2,
  parameter int unsigned ALMOST_FULL = 6
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush_i,
  input  logic                                 write_valid_i,
  output logic                                 write_ready_o,
  input  logic [WRITE_PORT-1:0]                write_mask_i,
  input  logic [WRITE_PORT*DATA_WIDTH-1:0]     write_data_i,
  output logic [READ_PORT-1:0]                 read_valid_o,
  output logic [READ_PORT*DATA_WIDTH-1:0]      read_data_o,
  input  logic                                 read_ready_i,
  input  logic [$clog2(READ_PORT+1)-1:0]       read_num_i,
  output logic [$clog2(DEPTH+1)-1:0]           count_o,
  output logic                                 almost_full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic [AW-1:0]         waddr [WRITE_PORT];
  logic [CW-1:0]         n_w;
  logic [CW-1:0]         n_r;
  logic [CW-1:0]         num_ext;
  logic                  wr_fire;
  logic                  rd_fire;

  // Status outputs derived from the registered occupancy only.
  always_comb begin
    write_ready_o = (count_q <= CW'(DEPTH - WRITE_PORT));
    almost_full_o = (count_q >= CW'(ALMOST_FULL));
    count_o       = count_q;
  end

  // Read lanes: the j-th oldest entry and its thermometer valid bit.
  always_comb begin
    read_valid_o = '0;
    read_data_o  = '0;
    for (int unsigned j = 0; j < READ_PORT; j++) begin
      read_valid_o[j]                         = (count_q > CW'(j));
      read_data_o[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[rptr_q + AW'(j)];
    end
  end

  // Compaction: each set lane lands at wptr plus the number of set lanes below it.
  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < WRITE_PORT; k++) begin
      waddr[k] = wptr_q + acc[AW-1:0];
      acc      = acc + CW'(write_mask_i[k]);
    end
    n_w = acc;
  end

  // Next-state: fire qualification, pop clipping, pointer/count/memory update.
  always_comb begin
    wr_fire = write_valid_i & write_ready_o & ~flush_i;
    rd_fire = read_ready_i & ~flush_i;
    num_ext = CW'(read_num_i);
    n_r     = (num_ext > count_q) ? count_q : num_ext;

    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;

    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_fire) begin
        for (int unsigned k = 0; k < WRITE_PORT; k++) begin
          if (write_mask_i[k]) begin
            mem_d[waddr[k]] = write_data_i[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        wptr_d = wptr_q + n_w[AW-1:0];
      end
      if (rd_fire) begin
        rptr_d = rptr_q + n_r[AW-1:0];
      end
      count_d = count_q + (wr_fire ? n_w : '0) - (rd_fire ? n_r : '0);
    end
  end

  // State registers; reset clears storage so read_data_o starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

endmodule
